// File: rtl/rf_issue_arbiter.sv
// rf_issue_arbiter
//   Picks at most one eligible head per cycle from the integer issue queue (IQ)
//   or the load/store queue (LSQ), pops it, and registers the payload, valid bit
//   and memory-type bit for the single register-read stage. Arbitration is
//   weighted round-robin: a two-state preference machine plus a burst counter
//   give the preferred side up to its weight in consecutive contended grants.
//
// Ports
//   CLK                    clock, rising edge
//   RESET                  synchronous, active-low reset
//   FREEZE                 pipeline stall: no pops, all state held
//   FLUSH                  kills the output slot, resets preference (beats FREEZE)
//   IQ_empty/IQ_head_rdy   IQ occupancy and head operand readiness
//   IQ_popData             IQ head payload
//   LSQ_empty/LSQ_head_rdy LSQ occupancy and head address readiness
//   LSQ_popData            LSQ head payload
//   Mem_busy               data cache busy; LSQ ineligible
//   IQ_pop/LSQ_pop         combinational pop strobes
//   IQLSQ_popData_OUT      registered selected payload
//   Valid_Instruction_OUT  registered valid
//   Mem_Instruction_OUT    registered, 1 = payload came from LSQ
//   Pref_state             debug: 0 = PREF_IQ, 1 = PREF_LSQ
module rf_issue_arbiter #(
  parameter int DATA_WIDTH = 137,
  parameter int IQ_WEIGHT  = 2,
  parameter int LSQ_WEIGHT = 1,
  parameter int BURST_W    = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  FREEZE,
  input  logic                  FLUSH,
  input  logic                  IQ_empty,
  input  logic                  IQ_head_rdy,
  input  logic [DATA_WIDTH-1:0] IQ_popData,
  input  logic                  LSQ_empty,
  input  logic                  LSQ_head_rdy,
  input  logic [DATA_WIDTH-1:0] LSQ_popData,
  input  logic                  Mem_busy,
  output logic                  IQ_pop,
  output logic                  LSQ_pop,
  output logic [DATA_WIDTH-1:0] IQLSQ_popData_OUT,
  output logic                  Valid_Instruction_OUT,
  output logic                  Mem_Instruction_OUT,
  output logic                  Pref_state
);

  typedef enum logic {
    PREF_IQ  = 1'b0,
    PREF_LSQ = 1'b1
  } pref_e;

  // Weights widened by one bit so burst+1 can be compared without overflow.
  localparam logic [BURST_W:0] IQ_W_C  = (BURST_W+1)'(IQ_WEIGHT);
  localparam logic [BURST_W:0] LSQ_W_C = (BURST_W+1)'(LSQ_WEIGHT);

  pref_e                 state_q, state_d;
  logic [BURST_W-1:0]    burst_q, burst_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  mem_q, mem_d;

  logic             iq_el, lsq_el, go;
  logic [BURST_W:0] burst_inc;
  logic [BURST_W:0] cur_weight;

  // RESET gates the pops so nothing leaves a queue on the clearing edge.
  assign iq_el  = !IQ_empty && IQ_head_rdy;
  assign lsq_el = !LSQ_empty && LSQ_head_rdy && !Mem_busy;
  assign go     = RESET && !FREEZE && !FLUSH;

  assign burst_inc  = {1'b0, burst_q} + 1'b1;
  assign cur_weight = (state_q == PREF_IQ) ? IQ_W_C : LSQ_W_C;

  always_comb begin
    IQ_pop  = 1'b0;
    LSQ_pop = 1'b0;
    state_d = state_q;
    burst_d = burst_q;
    if (go) begin
      if (state_q == PREF_IQ) begin
        if (iq_el)       IQ_pop  = 1'b1;
        else if (lsq_el) LSQ_pop = 1'b1;
      end else begin
        if (lsq_el)      LSQ_pop = 1'b1;
        else if (iq_el)  IQ_pop  = 1'b1;
      end
      // Only contended cycles count toward the burst; the preferred side
      // always wins them, so no extra grant check is needed.
      if (iq_el && lsq_el) begin
        if (burst_inc == cur_weight) begin
          state_d = (state_q == PREF_IQ) ? PREF_LSQ : PREF_IQ;
          burst_d = '0;
        end else begin
          burst_d = burst_inc[BURST_W-1:0];
        end
      end
    end
  end

  always_comb begin
    valid_d = IQ_pop || LSQ_pop;
    mem_d   = LSQ_pop;
    data_d  = '0;
    if (IQ_pop)       data_d = IQ_popData;
    else if (LSQ_pop) data_d = LSQ_popData;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= PREF_IQ;
      burst_q <= '0;
      valid_q <= 1'b0;
      mem_q   <= 1'b0;
      data_q  <= '0;
    end else if (FLUSH) begin
      // Payload is left alone; valid=0 makes it dead.
      state_q <= PREF_IQ;
      burst_q <= '0;
      valid_q <= 1'b0;
      mem_q   <= 1'b0;
    end else if (!FREEZE) begin
      state_q <= state_d;
      burst_q <= burst_d;
      valid_q <= valid_d;
      mem_q   <= mem_d;
      data_q  <= data_d;
    end
  end

  assign IQLSQ_popData_OUT     = data_q;
  assign Valid_Instruction_OUT = valid_q;
  assign Mem_Instruction_OUT   = mem_q;
  assign Pref_state            = state_q;

endmodule

// File: tb/tb_rf_issue_arbiter.sv
module tb_rf_issue_arbiter;

  localparam int DW = 137;

  logic          CLK = 1'b0;
  logic          RESET, FREEZE, FLUSH;
  logic          IQ_empty, IQ_head_rdy, LSQ_empty, LSQ_head_rdy, Mem_busy;
  logic [DW-1:0] IQ_popData, LSQ_popData;
  logic          IQ_pop, LSQ_pop;
  logic [DW-1:0] IQLSQ_popData_OUT;
  logic          Valid_Instruction_OUT, Mem_Instruction_OUT, Pref_state;

  int checks = 0;
  int passed = 0;

  rf_issue_arbiter #(
    .DATA_WIDTH(DW), .IQ_WEIGHT(2), .LSQ_WEIGHT(1), .BURST_W(4)
  ) dut (
    .CLK(CLK), .RESET(RESET), .FREEZE(FREEZE), .FLUSH(FLUSH),
    .IQ_empty(IQ_empty), .IQ_head_rdy(IQ_head_rdy), .IQ_popData(IQ_popData),
    .LSQ_empty(LSQ_empty), .LSQ_head_rdy(LSQ_head_rdy), .LSQ_popData(LSQ_popData),
    .Mem_busy(Mem_busy), .IQ_pop(IQ_pop), .LSQ_pop(LSQ_pop),
    .IQLSQ_popData_OUT(IQLSQ_popData_OUT),
    .Valid_Instruction_OUT(Valid_Instruction_OUT),
    .Mem_Instruction_OUT(Mem_Instruction_OUT), .Pref_state(Pref_state)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want done");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic iq_e, input logic iq_r, input logic lsq_e,
                       input logic lsq_r, input logic mb);
    IQ_empty = iq_e; IQ_head_rdy = iq_r;
    LSQ_empty = lsq_e; LSQ_head_rdy = lsq_r; Mem_busy = mb;
  endtask

  task automatic test_reset();
    RESET = 1'b0; FREEZE = 1'b0; FLUSH = 1'b0;
    IQ_popData = DW'(137'h111); LSQ_popData = DW'(137'h222);
    drive(0, 1, 0, 1, 0);
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (IQ_pop !== 1'b0) $display("FAIL reset_iq_pop: got %b want 0", IQ_pop); else passed++;
      checks++; if (LSQ_pop !== 1'b0) $display("FAIL reset_lsq_pop: got %b want 0", LSQ_pop); else passed++;
      tick();
      checks++; if (Valid_Instruction_OUT !== 1'b0) $display("FAIL reset_valid: got %b want 0", Valid_Instruction_OUT); else passed++;
      checks++; if (Mem_Instruction_OUT !== 1'b0) $display("FAIL reset_mem: got %b want 0", Mem_Instruction_OUT); else passed++;
      checks++; if (Pref_state !== 1'b0) $display("FAIL reset_pref: got %b want 0", Pref_state); else passed++;
      checks++; if (IQLSQ_popData_OUT !== '0) $display("FAIL reset_data: got %h want 0", IQLSQ_popData_OUT); else passed++;
    end
    drive(1, 0, 1, 0, 0);
    RESET = 1'b1;
    tick();
  endtask

  task automatic test_contention();
    logic          exp_lsq  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic          exp_pref [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [DW-1:0] exp_d;
    drive(0, 1, 0, 1, 0);
    for (int c = 0; c < 6; c++) begin
      IQ_popData  = DW'(137'h100) + DW'(c);
      LSQ_popData = DW'(137'h200) + DW'(c);
      exp_d = exp_lsq[c] ? LSQ_popData : IQ_popData;
      #1;
      checks++; if (IQ_pop !== !exp_lsq[c]) $display("FAIL cont_iq_pop[%0d]: got %b want %b", c, IQ_pop, !exp_lsq[c]); else passed++;
      checks++; if (LSQ_pop !== exp_lsq[c]) $display("FAIL cont_lsq_pop[%0d]: got %b want %b", c, LSQ_pop, exp_lsq[c]); else passed++;
      tick();
      checks++; if (Mem_Instruction_OUT !== exp_lsq[c]) $display("FAIL cont_mem[%0d]: got %b want %b", c, Mem_Instruction_OUT, exp_lsq[c]); else passed++;
      checks++; if (Valid_Instruction_OUT !== 1'b1) $display("FAIL cont_valid[%0d]: got %b want 1", c, Valid_Instruction_OUT); else passed++;
      checks++; if (IQLSQ_popData_OUT !== exp_d) $display("FAIL cont_data[%0d]: got %h want %h", c, IQLSQ_popData_OUT, exp_d); else passed++;
      checks++; if (Pref_state !== exp_pref[c]) $display("FAIL cont_pref[%0d]: got %b want %b", c, Pref_state, exp_pref[c]); else passed++;
    end
    // Both queues empty: nothing popped, output goes invalid, FSM untouched.
    drive(1, 0, 1, 0, 0);
    #1;
    checks++; if ({IQ_pop, LSQ_pop} !== 2'b00) $display("FAIL empty_pops: got %b want 00", {IQ_pop, LSQ_pop}); else passed++;
    tick();
    checks++; if (Valid_Instruction_OUT !== 1'b0) $display("FAIL empty_valid: got %b want 0", Valid_Instruction_OUT); else passed++;
    checks++; if (IQLSQ_popData_OUT !== '0) $display("FAIL empty_data: got %h want 0", IQLSQ_popData_OUT); else passed++;
    checks++; if (Pref_state !== 1'b0) $display("FAIL empty_pref: got %b want 0", Pref_state); else passed++;
  endtask

  task automatic test_iq_only();
    logic exp_lsq [3] = '{1'b0, 1'b0, 1'b1};
    drive(0, 1, 1, 1, 0);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if ({IQ_pop, LSQ_pop} !== 2'b10) $display("FAIL iqonly_pops[%0d]: got %b want 10", c, {IQ_pop, LSQ_pop}); else passed++;
      tick();
      checks++; if (Pref_state !== 1'b0) $display("FAIL iqonly_pref[%0d]: got %b want 0", c, Pref_state); else passed++;
      checks++; if ({Valid_Instruction_OUT, Mem_Instruction_OUT} !== 2'b10) $display("FAIL iqonly_vm[%0d]: got %b want 10", c, {Valid_Instruction_OUT, Mem_Instruction_OUT}); else passed++;
    end
    drive(0, 1, 0, 1, 0);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if ({IQ_pop, LSQ_pop} !== {!exp_lsq[c], exp_lsq[c]}) $display("FAIL iqonly_after[%0d]: got %b want %b", c, {IQ_pop, LSQ_pop}, {!exp_lsq[c], exp_lsq[c]}); else passed++;
      tick();
    end
    drive(1, 0, 1, 0, 0);
    tick();
  endtask

  task automatic test_mem_busy();
    logic          exp_lsq [3] = '{1'b0, 1'b0, 1'b1};
    logic [DW-1:0] lsq_val;
    lsq_val = {32'hDEADBEEF, 105'hABCD};
    LSQ_popData = lsq_val;
    IQ_popData  = DW'(137'h333);
    drive(1, 0, 0, 1, 1);
    #1;
    checks++; if ({IQ_pop, LSQ_pop} !== 2'b00) $display("FAIL mb_pops: got %b want 00", {IQ_pop, LSQ_pop}); else passed++;
    tick();
    checks++; if (Valid_Instruction_OUT !== 1'b0) $display("FAIL mb_valid: got %b want 0", Valid_Instruction_OUT); else passed++;
    Mem_busy = 1'b0;
    #1;
    checks++; if ({IQ_pop, LSQ_pop} !== 2'b01) $display("FAIL mb_release_pops: got %b want 01", {IQ_pop, LSQ_pop}); else passed++;
    tick();
    checks++; if ({Valid_Instruction_OUT, Mem_Instruction_OUT} !== 2'b11) $display("FAIL mb_release_vm: got %b want 11", {Valid_Instruction_OUT, Mem_Instruction_OUT}); else passed++;
    checks++; if (IQLSQ_popData_OUT !== lsq_val) $display("FAIL mb_release_data: got %h want %h", IQLSQ_popData_OUT, lsq_val); else passed++;
    // IQ granted uncontended while LSQ is blocked by Mem_busy.
    drive(0, 1, 0, 1, 1);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if ({IQ_pop, LSQ_pop} !== 2'b10) $display("FAIL mb_iq_pops[%0d]: got %b want 10", c, {IQ_pop, LSQ_pop}); else passed++;
      tick();
      checks++; if (Pref_state !== 1'b0) $display("FAIL mb_iq_pref[%0d]: got %b want 0", c, Pref_state); else passed++;
    end
    Mem_busy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if ({IQ_pop, LSQ_pop} !== {!exp_lsq[c], exp_lsq[c]}) $display("FAIL mb_after[%0d]: got %b want %b", c, {IQ_pop, LSQ_pop}, {!exp_lsq[c], exp_lsq[c]}); else passed++;
      tick();
    end
    drive(1, 0, 1, 0, 0);
    tick();
  endtask

  task automatic test_freeze();
    drive(0, 1, 0, 1, 0);
    IQ_popData = DW'(137'h5A5A);
    LSQ_popData = DW'(137'h6B6B);
    #1;
    checks++; if (IQ_pop !== 1'b1) $display("FAIL frz_pre_pop: got %b want 1", IQ_pop); else passed++;
    tick();
    checks++; if (IQLSQ_popData_OUT !== DW'(137'h5A5A)) $display("FAIL frz_pre_data: got %h want 5a5a", IQLSQ_popData_OUT); else passed++;
    FREEZE = 1'b1;
    IQ_popData = DW'(137'h7777);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if ({IQ_pop, LSQ_pop} !== 2'b00) $display("FAIL frz_pops[%0d]: got %b want 00", c, {IQ_pop, LSQ_pop}); else passed++;
      tick();
      checks++; if ({Valid_Instruction_OUT, Mem_Instruction_OUT, Pref_state} !== 3'b100) $display("FAIL frz_hold[%0d]: got %b want 100", c, {Valid_Instruction_OUT, Mem_Instruction_OUT, Pref_state}); else passed++;
      checks++; if (IQLSQ_popData_OUT !== DW'(137'h5A5A)) $display("FAIL frz_data[%0d]: got %h want 5a5a", c, IQLSQ_popData_OUT); else passed++;
    end
    FREEZE = 1'b0;
    // Burst was 1 before the freeze, so this IQ grant ends the IQ burst.
    #1;
    checks++; if ({IQ_pop, LSQ_pop} !== 2'b10) $display("FAIL frz_resume_pops: got %b want 10", {IQ_pop, LSQ_pop}); else passed++;
    tick();
    checks++; if (IQLSQ_popData_OUT !== DW'(137'h7777)) $display("FAIL frz_resume_data: got %h want 7777", IQLSQ_popData_OUT); else passed++;
    checks++; if (Pref_state !== 1'b1) $display("FAIL frz_resume_pref: got %b want 1", Pref_state); else passed++;
    #1;
    checks++; if ({IQ_pop, LSQ_pop} !== 2'b01) $display("FAIL frz_resume_lsq: got %b want 01", {IQ_pop, LSQ_pop}); else passed++;
    tick();
    checks++; if ({Mem_Instruction_OUT, Pref_state} !== 2'b10) $display("FAIL frz_resume_mp: got %b want 10", {Mem_Instruction_OUT, Pref_state}); else passed++;
    drive(1, 0, 1, 0, 0);
    tick();
  endtask

  task automatic test_flush();
    drive(0, 1, 0, 1, 0);
    #1; tick();
    #1; tick();
    checks++; if (Pref_state !== 1'b1) $display("FAIL fl_pre_pref: got %b want 1", Pref_state); else passed++;
    FLUSH = 1'b1; FREEZE = 1'b1;
    #1;
    checks++; if ({IQ_pop, LSQ_pop} !== 2'b00) $display("FAIL fl_pops: got %b want 00", {IQ_pop, LSQ_pop}); else passed++;
    tick();
    checks++; if ({Valid_Instruction_OUT, Mem_Instruction_OUT, Pref_state} !== 3'b000) $display("FAIL fl_out: got %b want 000", {Valid_Instruction_OUT, Mem_Instruction_OUT, Pref_state}); else passed++;
    FLUSH = 1'b0; FREEZE = 1'b0;
    #1;
    checks++; if ({IQ_pop, LSQ_pop} !== 2'b10) $display("FAIL fl_next_pops: got %b want 10", {IQ_pop, LSQ_pop}); else passed++;
    tick();
    checks++; if (Pref_state !== 1'b0) $display("FAIL fl_next_pref: got %b want 0", Pref_state); else passed++;
    #1;
    checks++; if ({IQ_pop, LSQ_pop} !== 2'b10) $display("FAIL fl_second_pops: got %b want 10", {IQ_pop, LSQ_pop}); else passed++;
    tick();
    checks++; if (Pref_state !== 1'b1) $display("FAIL fl_second_pref: got %b want 1", Pref_state); else passed++;
  endtask

  task automatic test_reset_midstream();
    // Entered in PREF_LSQ with a valid output and both queues eligible.
    RESET = 1'b0;
    #1;
    checks++; if ({IQ_pop, LSQ_pop} !== 2'b00) $display("FAIL rstmid_pops: got %b want 00", {IQ_pop, LSQ_pop}); else passed++;
    tick();
    checks++; if ({Valid_Instruction_OUT, Pref_state} !== 2'b00) $display("FAIL rstmid_vp: got %b want 00", {Valid_Instruction_OUT, Pref_state}); else passed++;
    checks++; if (IQLSQ_popData_OUT !== '0) $display("FAIL rstmid_data: got %h want 0", IQLSQ_popData_OUT); else passed++;
    RESET = 1'b1;
    #1;
    checks++; if ({IQ_pop, LSQ_pop} !== 2'b10) $display("FAIL rstmid_after: got %b want 10", {IQ_pop, LSQ_pop}); else passed++;
    tick();
    drive(1, 0, 1, 0, 0);
    tick();
  endtask

  initial begin
    test_reset();
    test_contention();
    test_iq_only();
    test_mem_busy();
    test_freeze();
    test_flush();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
